// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared FSM states, requester ids and wait-counter width for the data-memory arbiter
package dmem_arb_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;
    typedef enum logic {REQ_CPU = 1'b0, REQ_EXT = 1'b1} req_id_t;
    localparam int CNT_W = 4;
endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: CPU, EXT and memory-side signals of the data-memory arbiter
interface dmem_arbiter_if #(parameter int DW = 32, parameter int AW = 6);
    logic          cpu_req, cpu_we, cpu_stall;
    logic [31:0]   cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          ext_req, ext_we, ext_ack;
    logic [31:0]   ext_addr;
    logic [DW-1:0] ext_wdata, ext_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, ext_req, ext_we, ext_addr, ext_wdata, mem_rdata,
        output cpu_rdata, cpu_stall, ext_rdata, ext_ack, mem_en, mem_we, mem_addr, mem_wdata
    );
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, ext_req, ext_we, ext_addr, ext_wdata, mem_rdata,
        input  cpu_rdata, cpu_stall, ext_rdata, ext_ack, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// rr_arb2: two-input round-robin arbiter with a `last` pointer updated on every accepted grant.
// DMEM_ARB_CPU_PRIO_EN selects fixed CPU priority instead (pointer still maintained).
module rr_arb2 import dmem_arb_pkg::*; (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       accept,
    output req_id_t    gnt
);
    req_id_t last;
    always_ff @(posedge clk) begin
        if (rst)
            last <= REQ_EXT;
        else if (accept)
            last <= gnt;
    end
`ifdef DMEM_ARB_CPU_PRIO_EN
    assign gnt = req[REQ_CPU] ? REQ_CPU : req[REQ_EXT] ? REQ_EXT : last;
`else
    // on a tie the requester that was not served last wins
    assign gnt = (req[REQ_CPU] && req[REQ_EXT]) ? (last == REQ_CPU ? REQ_EXT : REQ_CPU)
               : req[REQ_CPU] ? REQ_CPU : req[REQ_EXT] ? REQ_EXT : last;
`endif
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the MEM stage and the EXT port,
// inserting WAIT extra access cycles and stalling the pipeline until the CPU access completes.
module dmem_arbiter import dmem_arb_pkg::*; #(
    parameter int DW   = 32,
    parameter int AW   = 6,
    parameter int WAIT = 1
) (
    input logic            clk,
    input logic            rst,
    dmem_arbiter_if.slave  bus
);
    state_t        state, nstate;
    req_id_t       gnt, gnt_q;
    logic          we_q, start, last_beat, sel_cpu;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q, rdata_q;
    logic [CNT_W-1:0] cnt;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    ({bus.ext_req, bus.cpu_req}),
        .accept (start),
        .gnt    (gnt)
    );

    assign sel_cpu   = gnt == REQ_CPU;
    assign last_beat = cnt == '0;

    always_comb begin
        start  = state == IDLE && (bus.cpu_req || bus.ext_req);
        nstate = start ? ACCESS : (state == ACCESS && last_beat) ? RESP : (state == RESP) ? IDLE : state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            gnt_q   <= REQ_CPU;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt     <= '0;
        end else begin
            state <= nstate;
            if (start) begin
                gnt_q   <= gnt;
                we_q    <= sel_cpu ? bus.cpu_we : bus.ext_we;
                addr_q  <= sel_cpu ? bus.cpu_addr[AW+1:2] : bus.ext_addr[AW+1:2];
                wdata_q <= sel_cpu ? bus.cpu_wdata : bus.ext_wdata;
                cnt     <= CNT_W'(WAIT);
            end else if (state == ACCESS) begin
                if (last_beat)
                    rdata_q <= bus.mem_rdata;
                else
                    cnt <= cnt - 1'b1;
            end
        end
    end

    assign bus.mem_en    = state == ACCESS;
    // rst gating drops a write whose strobe cycle coincides with reset
    assign bus.mem_we    = state == ACCESS && we_q && last_beat && !rst;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.cpu_rdata = rdata_q;
    assign bus.ext_rdata = rdata_q;
    assign bus.cpu_stall = bus.cpu_req && !(state == RESP && gnt_q == REQ_CPU);
    assign bus.ext_ack   = state == RESP && gnt_q == REQ_EXT;
endmodule
